// File: rtl/psg_bus_writer_pkg.sv
// Shared PSG definitions: register-select codes and the latch/data byte formats
// that appear on the PSG data bus. Used by the bus writer and the PSG core.
package psg_bus_writer_pkg;

  localparam logic [2:0] REG_TONE0 = 3'b000;
  localparam logic [2:0] REG_ATTN0 = 3'b001;
  localparam logic [2:0] REG_TONE1 = 3'b010;
  localparam logic [2:0] REG_ATTN1 = 3'b011;
  localparam logic [2:0] REG_TONE2 = 3'b100;
  localparam logic [2:0] REG_ATTN2 = 3'b101;
  localparam logic [2:0] REG_NOISE = 3'b110;
  localparam logic [2:0] REG_ATTN3 = 3'b111;

  localparam logic       LATCH_FLAG  = 1'b1;
  localparam logic [1:0] DATA_PREFIX = 2'b00;

  localparam int CMD_W = 13;

  typedef struct packed {
    logic [2:0] regSel;
    logic [9:0] value;
  } psg_cmd_t;

  function automatic logic is_tone(input logic [2:0] sel);
    return (sel[0] == 1'b0) && (sel != REG_NOISE);
  endfunction

  // Noise only has a 3-bit control field; its top nibble bit is always zero.
  function automatic logic [7:0] latch_byte(input psg_cmd_t cmd);
    logic [3:0] nib;
    nib = (cmd.regSel == REG_NOISE) ? {1'b0, cmd.value[2:0]} : cmd.value[3:0];
    return {LATCH_FLAG, cmd.regSel, nib};
  endfunction

  function automatic logic [7:0] data_byte(input logic [9:0] value);
    return {DATA_PREFIX, value[9:4]};
  endfunction

endpackage

// File: rtl/psg_cmd_fifo.sv
// Small synchronous command FIFO for the PSG bus writer. Push is ignored when
// full and pop is ignored when empty, so the occupancy can never wrap.
module psg_cmd_fifo
  import psg_bus_writer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CMD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushData_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] popData_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [AW:0]      count_q;
  logic             doPush;
  logic             doPop;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign doPush    = push_i && !full_o;
  assign doPop     = pop_i && !empty_o;
  assign popData_o = mem_q[rdPtr_q];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= pushData_i;
  end

endmodule

// File: rtl/psg_bus_writer.sv
// Queues PSG register writes and serialises them onto the 8-bit PSG bus as a
// latch byte plus an optional data byte, each framed by a we_n low pulse.
module psg_bus_writer
  import psg_bus_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WE_CYCLES  = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_reg,
  input  logic [9:0] cmd_value,
  output logic [7:0] data_out,
  output logic       we_n,
  output logic       busy
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LATCH_WE  = 3'd1;
  localparam logic [2:0] ST_LATCH_GAP = 3'd2;
  localparam logic [2:0] ST_DATA_WE   = 3'd3;
  localparam logic [2:0] ST_DATA_GAP  = 3'd4;

  localparam int MAXC = (WE_CYCLES > GAP_CYCLES) ? WE_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] WE_LAST  = CW'(WE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  psg_cmd_t      pushCmd;
  psg_cmd_t      popCmd;
  logic          fifoFull;
  logic          fifoEmpty;
  logic          fifoPop;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    dataByte_q, dataByte_d;
  logic [7:0]    dataOut_q, dataOut_d;
  logic          needsData_q, needsData_d;
  logic [1:0]    toneIdx_q, toneIdx_d;
  logic          weN_q, weN_d;
  logic [5:0]    shadow_q [4];
  logic          shadowWr;

  assign pushCmd   = '{regSel: cmd_reg, value: cmd_value};
  assign cmd_ready = !fifoFull;
  assign fifoPop   = (state_q == ST_IDLE) && !fifoEmpty;
  assign busy      = !fifoEmpty || (state_q != ST_IDLE);
  assign we_n      = weN_q;
  assign data_out  = dataOut_q;

  psg_cmd_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(CMD_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (cmd_valid),
    .pushData_i (pushCmd),
    .pop_i      (fifoPop),
    .popData_o  (popCmd),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty)
  );

  // weN_d and dataOut_d describe the next state, so the strobe and bus are
  // registered outputs that change exactly with the state transitions.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dataByte_d  = dataByte_q;
    dataOut_d   = dataOut_q;
    needsData_d = needsData_q;
    toneIdx_d   = toneIdx_q;
    weN_d       = 1'b1;
    shadowWr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifoEmpty) begin
          dataOut_d   = latch_byte(popCmd);
          dataByte_d  = data_byte(popCmd.value);
          toneIdx_d   = popCmd.regSel[2:1];
          needsData_d = is_tone(popCmd.regSel) &&
                        (popCmd.value[9:4] != shadow_q[popCmd.regSel[2:1]]);
          cnt_d       = '0;
          weN_d       = 1'b0;
          state_d     = ST_LATCH_WE;
        end
      end
      ST_LATCH_WE: begin
        if (cnt_q == WE_LAST) begin
          cnt_d   = '0;
          state_d = ST_LATCH_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
          weN_d = 1'b0;
        end
      end
      ST_LATCH_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (needsData_q) begin
            dataOut_d = dataByte_q;
            weN_d     = 1'b0;
            state_d   = ST_DATA_WE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA_WE: begin
        if (cnt_q == WE_LAST) begin
          cnt_d    = '0;
          shadowWr = 1'b1;
          state_d  = ST_DATA_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
          weN_d = 1'b0;
        end
      end
      ST_DATA_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dataByte_q  <= '0;
      dataOut_q   <= '0;
      needsData_q <= 1'b0;
      toneIdx_q   <= '0;
      weN_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dataByte_q  <= dataByte_d;
      dataOut_q   <= dataOut_d;
      needsData_q <= needsData_d;
      toneIdx_q   <= toneIdx_d;
      weN_q       <= weN_d;
    end
  end

  // Zero matches the PSG's own tone reset value, so a first write with zero
  // high bits correctly skips its data byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) shadow_q[i] <= '0;
    end else if (shadowWr) begin
      shadow_q[toneIdx_q] <= dataByte_q[5:0];
    end
  end

endmodule

// File: tb/tb_psg_bus_writer.sv
// Directed and random checks of psg_bus_writer against a command-level byte
// model and a decoding PSG register model fed from the observed bus.
module tb_psg_bus_writer;

  localparam int WE_CYCLES  = 2;
  localparam int GAP_CYCLES = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmdValid = 1'b0;
  logic       cmdReady;
  logic [2:0] cmdReg = '0;
  logic [9:0] cmdValue = '0;
  logic [7:0] dataOut;
  logic       weN;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  int          expQ[$];
  logic [7:0]  byteLog[$];
  int          mShadow[3];
  int          modelBytes = 0;

  logic [9:0]  psgTone[3];
  logic [3:0]  psgAttn[4];
  logic [2:0]  psgNoise = '0;
  logic [2:0]  psgLatch = '0;
  int          noiseRestarts = 0;

  int          lowCount = 0;
  int          gapCount = 0;
  logic        haveByte = 1'b0;
  logic [7:0]  curByte = '0;

  psg_bus_writer #(
    .FIFO_DEPTH(4),
    .WE_CYCLES (WE_CYCLES),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk      (clk),
    .reset    (rst),
    .cmd_valid(cmdValid),
    .cmd_ready(cmdReady),
    .cmd_reg  (cmdReg),
    .cmd_value(cmdValue),
    .data_out (dataOut),
    .we_n     (weN),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Expected bus bytes per command, written straight from the byte-format rules.
  task automatic modelPush(input int r, input int v);
    int hi;
    int idx;
    if (r == 6) begin
      expQ.push_back(128 + 6 * 16 + (v % 8));
      modelBytes++;
    end else begin
      expQ.push_back(128 + r * 16 + (v % 16));
      modelBytes++;
      if (r % 2 == 0) begin
        hi  = v / 16;
        idx = r / 2;
        if (hi != mShadow[idx]) begin
          expQ.push_back(hi);
          modelBytes++;
          mShadow[idx] = hi;
        end
      end
    end
  endtask

  task automatic psgWrite(input logic [7:0] b);
    int sel;
    if (b[7]) begin
      psgLatch = b[6:4];
      sel = int'(b[6:4]);
      if (sel % 2 == 1) psgAttn[sel / 2] = b[3:0];
      else if (sel == 6) begin
        psgNoise = b[2:0];
        noiseRestarts++;
      end else psgTone[sel / 2] = (psgTone[sel / 2] & 10'h3F0) | {6'd0, b[3:0]};
    end else begin
      sel = int'(psgLatch);
      if (sel % 2 == 0 && sel != 6)
        psgTone[sel / 2] = (psgTone[sel / 2] & 10'h00F) | {b[5:0], 4'd0};
    end
  endtask

  // Bus monitor: every cycle checks strobe width, gap width, bus stability
  // and each byte against the head of the expected stream.
  always @(negedge clk) begin
    if (rst) begin
      lowCount = 0;
      gapCount = GAP_CYCLES;
      haveByte = 1'b0;
    end else if (weN === 1'b0) begin
      if (lowCount == 0) begin
        if (haveByte) checkOutput("gapWidth", (gapCount >= GAP_CYCLES), 1);
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpectedByte actual=0x%0h expected=none", dataOut);
        end else begin
          checkOutput("byteValue", dataOut, expQ[0]);
          void'(expQ.pop_front());
        end
        curByte = dataOut;
      end else begin
        checkOutput("byteStable", dataOut, curByte);
      end
      lowCount++;
    end else begin
      if (lowCount > 0) begin
        checkOutput("weLowCycles", lowCount, WE_CYCLES);
        byteLog.push_back(curByte);
        psgWrite(curByte);
        lowCount = 0;
        gapCount = 1;
        haveByte = 1'b1;
        checkOutput("gapHold", dataOut, curByte);
      end else begin
        gapCount++;
        if (haveByte && gapCount <= GAP_CYCLES) checkOutput("gapHold", dataOut, curByte);
      end
    end
  end

  task automatic applyStimulus(input int r, input int v);
    int waitCycles;
    waitCycles = 0;
    cmdReg   = 3'(r);
    cmdValue = 10'(v);
    cmdValid = 1'b1;
    while (cmdReady !== 1'b1 && waitCycles < 200) begin
      @(negedge clk);
      #1;
      waitCycles++;
    end
    if (cmdReady !== 1'b1) begin
      checkOutput("pushTimeout", cmdReady, 1);
      cmdValid = 1'b0;
    end else begin
      modelPush(r, v);
      @(posedge clk);
      #1;
      cmdValid = 1'b0;
    end
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drainBusy", busy, 0);
    repeat (2) @(negedge clk);
    checkOutput("expQueueDrained", expQ.size(), 0);
    #1;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    cmdValid = 1'b0;
    expQ.delete();
    byteLog.delete();
    for (int i = 0; i < 3; i++) mShadow[i] = 0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("resetWeN", weN, 1);
    checkOutput("resetDataOut", dataOut, 0);
    checkOutput("resetCmdReady", cmdReady, 1);
    checkOutput("resetBusy", busy, 0);
    #1 rst = 1'b0;
  endtask

  task automatic expectLog2(input string name, input int n, input logic [7:0] b0, input logic [7:0] b1);
    checkOutput({name, "Size"}, byteLog.size(), n);
    if (byteLog.size() >= 1) checkOutput({name, "Byte0"}, byteLog[0], b0);
    if (n == 2 && byteLog.size() >= 2) checkOutput({name, "Byte1"}, byteLog[1], b1);
  endtask

  initial begin
    int n;
    int r0;
    for (int i = 0; i < 3; i++) psgTone[i] = '0;
    for (int i = 0; i < 4; i++) psgAttn[i] = '0;

    applyReset();

    // tone0 = 0x2A5 with the push-to-strobe latency pinned
    applyStimulus(0, 10'h2A5);
    checkOutput("latencyWeHighN1", weN, 1);
    checkOutput("latencyBusyN1", busy, 1);
    @(posedge clk);
    #1;
    checkOutput("latencyWeLowN2", weN, 0);
    checkOutput("latencyLatchByte", dataOut, 8'h85);
    waitIdle();
    expectLog2("tone0", 2, 8'h85, 8'h2A);
    checkOutput("psgTone0a", psgTone[0], 10'h2A5);

    byteLog.delete();
    applyStimulus(0, 10'h2A7);
    waitIdle();
    expectLog2("shadowHit", 1, 8'h87, 8'h00);
    checkOutput("psgTone0b", psgTone[0], 10'h2A7);
    byteLog.delete();
    applyStimulus(0, 10'h007);
    waitIdle();
    expectLog2("shadowMiss", 2, 8'h87, 8'h00);
    checkOutput("psgTone0c", psgTone[0], 10'h007);

    byteLog.delete();
    r0 = noiseRestarts;
    applyStimulus(5, 10'h00F);
    applyStimulus(6, 10'h3F5);
    waitIdle();
    expectLog2("attnNoise", 2, 8'hDF, 8'hE5);
    checkOutput("noiseRestart", noiseRestarts, r0 + 1);
    checkOutput("psgNoise", psgNoise, 3'd5);
    checkOutput("psgAttn2", psgAttn[2], 4'hF);

    // A filler command keeps the FSM busy so the next pushes pile up in the FIFO.
    byteLog.delete();
    applyStimulus(4, 10'h3C1);
    n = 0;
    while (weN !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    #1;
    applyStimulus(0, 10'h011);
    applyStimulus(2, 10'h022);
    applyStimulus(3, 10'h003);
    applyStimulus(4, 10'h044);
    checkOutput("fullAfterFour", cmdReady, 0);
    applyStimulus(6, 10'h002);
    waitIdle();
    checkOutput("burstLogSize", byteLog.size(), 10);
    if (byteLog.size() == 10) begin
      checkOutput("burstFirst", byteLog[0], 8'hC1);
      checkOutput("burstLast", byteLog[9], 8'hE2);
    end

    // Reset in the middle of tone1's data strobe with more commands queued.
    byteLog.delete();
    applyStimulus(2, 10'h155);
    waitIdle();
    applyStimulus(2, 10'h2B5);
    applyStimulus(1, 10'h003);
    applyStimulus(4, 10'h100);
    n = 0;
    @(negedge clk);
    while (!(weN === 1'b0 && dataOut === 8'h2B) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reachedDataWe", dataOut, 8'h2B);
    #2 rst = 1'b1;
    expQ.delete();
    for (int i = 0; i < 3; i++) mShadow[i] = 0;
    #1;
    checkOutput("asyncResetWeN", weN, 1);
    checkOutput("asyncResetBusy", busy, 0);
    checkOutput("asyncResetData", dataOut, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    byteLog.delete();
    repeat (20) @(negedge clk);
    checkOutput("noBytesAfterReset", byteLog.size(), 0);
    checkOutput("idleAfterReset", busy, 0);
    #1;
    applyStimulus(2, 10'h155);
    waitIdle();
    expectLog2("shadowCleared", 2, 8'hA5, 8'h15);

    // Random stream pushed as fast as accepted: FIFO sits at full most of the time.
    byteLog.delete();
    modelBytes = 0;
    for (int i = 0; i < 100; i++) applyStimulus($urandom_range(0, 7), $urandom_range(0, 1023));
    waitIdle();
    checkOutput("randomByteCount", byteLog.size(), modelBytes);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
